// File: rtl/opamp_model_pkg.sv
// Shared types and helpers for the behavioural op-amp model family.
package opamp_model_pkg;

    localparam int RAIL_HI_DEF = 30000;
    localparam int RAIL_LO_DEF = -30000;

    typedef struct packed {
        logic signed [63:0] value;
        logic               flag;
    } clip_t;

    // Limit a wide value to [lo, hi]; flag reports that a rail was hit.
    function automatic clip_t clip(input logic signed [63:0] value,
                                   input logic signed [63:0] lo,
                                   input logic signed [63:0] hi);
        clip_t r;
        r.value = value;
        r.flag  = 1'b0;
        if (value > hi) begin
            r.value = hi;
            r.flag  = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.flag  = 1'b1;
        end
        return r;
    endfunction

    // Channel index width; a single channel still gets one bit.
    function automatic int chw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/opamp_pole_stage.sv
// Combinational single-pole update: shifted residual, slew clamp, new state.
module opamp_pole_stage #(
    parameter int W          = 16,
    parameter int POLE_SHIFT = 6,
    parameter int SLEW_MAX   = 256
) (
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] target,
    output logic signed [W-1:0] y_new,
    output logic                slew
);

    localparam logic signed [W:0] SMAX = (W+1)'(SLEW_MAX);

    logic signed [W:0] e;
    logic signed [W:0] delta;
    logic signed [W:0] sum;

    // Residual is floored by the arithmetic shift, then limited to +/-SLEW_MAX.
    always_comb begin
        e     = {target[W-1], target} - {y[W-1], y};
        delta = e >>> POLE_SHIFT;
        slew  = 1'b0;
        if (delta > SMAX) begin
            delta = SMAX;
            slew  = 1'b1;
        end else if (delta < -SMAX) begin
            delta = -SMAX;
            slew  = 1'b1;
        end
        sum   = {y[W-1], y} + delta;
        y_new = W'(sum);
    end

endmodule

// File: rtl/opamp_pole_model_mc.sv
// Time-multiplexed single-pole op-amp model: gain, rail clip, RC pole, slew limit.
module opamp_pole_model_mc
    import opamp_model_pkg::*;
#(
    parameter int W          = 16,
    parameter int CH         = 4,
    parameter int GAIN       = 64,
    parameter int POLE_SHIFT = 6,
    parameter int SLEW_MAX   = 256,
    parameter int RAIL_HI    = RAIL_HI_DEF,
    parameter int RAIL_LO    = RAIL_LO_DEF,
    localparam int CHW       = chw_of(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CHW-1:0]      s_ch,
    input  logic signed [W-1:0] s_in_p,
    input  logic signed [W-1:0] s_in_n,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CHW-1:0]      m_ch,
    output logic signed [W-1:0] m_y,
    output logic                m_sat,
    output logic                m_slew
);

    logic                s1_valid;
    logic [CHW-1:0]      s1_ch;
    logic signed [W-1:0] s1_target;
    logic                s1_sat;

    logic                adv;
    logic                accept;
    logic                ch_ok;
    logic signed [W:0]   diff;
    logic signed [63:0]  prod;
    clip_t               cr;

    logic signed [W-1:0] y_st [CH];
    logic signed [W-1:0] y_new;
    logic                slew;

    assign adv     = !m_valid || m_ready;
    assign s_ready = !rst && !clear && (!s1_valid || adv);
    assign accept  = s_valid && s_ready;
    assign ch_ok   = (int'(s_ch) < CH);

    // Open-loop gain at full precision, then limit to the supply rails.
    always_comb begin
        diff = {s_in_p[W-1], s_in_p} - {s_in_n[W-1], s_in_n};
        prod = 64'(diff) * 64'(GAIN);
        cr   = clip(prod, 64'(RAIL_LO), 64'(RAIL_HI));
    end

    // S1 register; out-of-range channels are accepted but never become valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_target <= '0;
            s1_sat    <= 1'b0;
        end else if (clear) begin
            s1_valid  <= 1'b0;
        end else if (accept) begin
            s1_valid <= ch_ok;
            if (ch_ok) begin
                s1_ch     <= s_ch;
                s1_target <= W'(cr.value);
                s1_sat    <= cr.flag;
            end
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    opamp_pole_stage #(
        .W          (W),
        .POLE_SHIFT (POLE_SHIFT),
        .SLEW_MAX   (SLEW_MAX)
    ) u_stage (
        .y      (y_st[s1_ch]),
        .target (s1_target),
        .y_new  (y_new),
        .slew   (slew)
    );

    // S2: channel state write-back and output register, stalled by backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_y     <= '0;
            m_sat   <= 1'b0;
            m_slew  <= 1'b0;
            for (int i = 0; i < CH; i++) y_st[i] <= '0;
        end else if (clear) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_y     <= '0;
            m_sat   <= 1'b0;
            m_slew  <= 1'b0;
            for (int i = 0; i < CH; i++) y_st[i] <= '0;
        end else if (adv) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                y_st[s1_ch] <= y_new;
                m_y         <= y_new;
                m_ch        <= s1_ch;
                m_sat       <= s1_sat;
                m_slew      <= slew;
            end
        end
    end

endmodule

// File: tb/tb_opamp_pole_model_mc.sv
// Directed scoreboard bench for the multi-channel op-amp pole model.
module tb_opamp_pole_model_mc;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               s_valid;
    logic               s_ready;
    logic [2:0]         s_ch;
    logic signed [15:0] s_in_p;
    logic signed [15:0] s_in_n;
    logic               m_valid;
    logic               m_ready;
    logic [2:0]         m_ch;
    logic signed [15:0] m_y;
    logic               m_sat;
    logic               m_slew;

    typedef struct {
        int ch;
        int y;
        bit sat;
        bit slew;
    } exp_t;

    exp_t sb[$];
    int   y_m [8];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    int   last_y = 0;
    int   base;

    // Five channels so that a 3-bit index can address a channel that does not exist.
    opamp_pole_model_mc #(.CH(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_ch    (s_ch),
        .s_in_p  (s_in_p),
        .s_in_n  (s_in_n),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ch    (m_ch),
        .m_y     (m_y),
        .m_sat   (m_sat),
        .m_slew  (m_slew)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: gain 64, rails +/-30000, floor divide by 64, slew 256.
    function automatic exp_t model(input int ch, input int p, input int n);
        exp_t   r;
        longint tgt, e, d;
        tgt   = 64 * (longint'(p) - longint'(n));
        r.sat = 0;
        if (tgt > 30000) begin
            tgt = 30000; r.sat = 1;
        end else if (tgt < -30000) begin
            tgt = -30000; r.sat = 1;
        end
        e = tgt - y_m[ch];
        d = e / 64;
        if (e < 0 && (e % 64) != 0) d = d - 1;
        r.slew = 0;
        if (d > 256) begin
            d = 256; r.slew = 1;
        end else if (d < -256) begin
            d = -256; r.slew = 1;
        end
        r.y  = int'(y_m[ch] + d);
        r.ch = ch;
        return r;
    endfunction

    task automatic drive(input int ch, input int p, input int n);
        s_valid = 1'b1;
        s_ch    = 3'(ch);
        s_in_p  = 16'(p);
        s_in_n  = 16'(n);
    endtask

    task automatic wait_accept(input int ch, input int p, input int n);
        bit   ok = 0;
        exp_t e;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                if (ch < 5) begin
                    e = model(ch, p, n);
                    y_m[ch] = e.y;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("accept_in_time", ok, 1);
    endtask

    task automatic send(input int ch, input int p, input int n);
        drive(ch, p, n);
        wait_accept(ch, p, n);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        sb.delete();
        for (int i = 0; i < 8; i++) y_m[i] = 0;
    endtask

    // Output monitor: every completed output transfer is compared with the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && !clear && m_valid && m_ready) begin
            n_out++;
            last_y = int'(m_y);
            check("output_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("m_ch", m_ch, e.ch);
                check("m_y", m_y, e.y);
                check("m_sat", m_sat, e.sat);
                check("m_slew", m_slew, e.slew);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s_ch = '0; s_in_p = '0; s_in_n = '0;
        reset_model();
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_y", m_y, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_sat", m_sat, 0);
        check("rst_m_slew", m_slew, 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Step on ch0, with latency check on the first sample
        send(0, 100, 0);
        @(negedge clk);
        check("latency_not_yet", m_valid, 0);
        @(negedge clk);
        check("latency_valid", m_valid, 1);
        check("step_first", m_y, 100);
        @(posedge clk); #1;
        send(0, 100, 0);
        drain();
        check("step_second", last_y, 198);

        // Negative step on ch1: floor rounding gives -99 on the second sample
        send(1, 0, 100);
        send(1, 0, 100);
        drain();
        check("neg_second", last_y, -199);

        // Rail clip and slew clamp on ch2
        send(2, 1000, 0);
        send(2, 1000, 0);
        drain();
        check("slew_second", last_y, 512);

        // clear has priority over a simultaneous input
        drive(0, 100, 0);
        clear = 1'b1;
        @(negedge clk);
        check("clear_s_ready", s_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        s_valid = 1'b0;
        reset_model();
        check("clear_m_valid", m_valid, 0);

        // Back-to-back interleave after clear: 100, 100, 198
        send(0, 100, 0);
        send(3, 100, 0);
        send(0, 100, 0);
        drain();
        check("interleave_last", last_y, 198);

        // Backpressure: two in flight, third held off while outputs hold
        base = n_out;
        m_ready = 1'b0;
        send(0, 100, 0);
        send(1, 100, 0);
        drive(2, -1000, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_s_ready", s_ready, 0);
            check("bp_m_valid", m_valid, 1);
            check("bp_hold_y", m_y, sb[0].y);
            check("bp_hold_ch", m_ch, sb[0].ch);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_accept(2, -1000, 0);
        send(3, 50, 0);
        drain();
        check("bp_count", n_out - base, 4);

        // Asynchronous reset mid-burst
        m_ready = 1'b0;
        send(0, 100, 0);
        send(1, 100, 0);
        #3 rst = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_y", m_y, 0);
        check("midrst_m_ch", m_ch, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_flags", {m_sat, m_slew}, 0);
        reset_model();
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        send(0, 100, 0);
        drain();
        check("after_rst", last_y, 100);

        // Non-existent channel: accepted, dropped, no state change
        base = n_out;
        send(5, 100, 0);
        repeat (6) @(posedge clk);
        #1;
        check("badch_no_output", n_out - base, 0);
        check("badch_m_valid", m_valid, 0);
        send(0, 100, 0);
        drain();
        check("badch_ch0_intact", last_y, 198);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
